// File: rtl/banked_sync_ram.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | banked_sync_ram                                                           |
// | Single-port synchronous RAM: byte-lane writes, valid/ready requests,      |
// | 1- or 2-cycle read latency, hardware init sweep after reset.              |
// | Optional per-byte even parity: define BANKED_SYNC_RAM_PARITY_EN.          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module banked_sync_ram #(
   parameter int                    ADDR_WIDTH   = 10,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    LENGTH       = 1 << ADDR_WIDTH,
   parameter int                    READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_start,
   output logic                    init_done,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic                    req_perr_inject,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [DATA_WIDTH/8-1:0] rsp_perr
);

   localparam int                  c_NB   = DATA_WIDTH / 8;
   localparam int                  c_IW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [ADDR_WIDTH:0] c_LEN  = (ADDR_WIDTH + 1)'(LENGTH);
   localparam logic [c_IW-1:0]     c_LAST = c_IW'(LENGTH - 1);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   logic [c_IW-1:0]       r_cnt;
   logic                  r_ready;
   logic                  r_init_done;
   logic                  r_s1_valid;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic [c_NB-1:0]       r_s1_perr;

   logic [DATA_WIDTH-1:0] r_mem [0:LENGTH-1];
`ifdef BANKED_SYNC_RAM_PARITY_EN
   logic [c_NB-1:0]       r_par [0:LENGTH-1];
   logic                  w_mem_pinj;
`else
   logic                  w_unused_perr_inject;
   assign w_unused_perr_inject = req_perr_inject;
`endif

   logic                  w_accept;
   logic                  w_in_range;
   logic [c_IW-1:0]       w_rd_idx;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic [c_NB-1:0]       w_rd_perr;
   logic                  w_mem_we;
   logic [c_IW-1:0]       w_mem_idx;
   logic [DATA_WIDTH-1:0] w_mem_wdata;
   logic [c_NB-1:0]       w_mem_be;

   // A request arriving with init_start is refused so the restart wins cleanly.
   assign req_ready  = r_ready & ~init_start;
   assign init_done  = r_init_done;
   assign w_accept   = req_valid & req_ready;
   assign w_in_range = ({1'b0, req_addr} < c_LEN);
   assign w_rd_idx   = req_addr[c_IW-1:0];
   assign w_rd_word  = w_in_range ? r_mem[w_rd_idx] : '0;

`ifdef BANKED_SYNC_RAM_PARITY_EN
   always_comb begin
      w_rd_perr = '0;
      if (w_in_range) begin
         for (int i = 0; i < c_NB; i++) begin
            w_rd_perr[i] = (^w_rd_word[8*i +: 8]) ^ r_par[w_rd_idx][i];
         end
      end
   end
`else
   assign w_rd_perr = '0;
`endif

   // Single write port shared by the init sweep and accepted in-range writes.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_idx   = r_cnt;
      w_mem_wdata = INIT_VALUE;
      w_mem_be    = '1;
`ifdef BANKED_SYNC_RAM_PARITY_EN
      w_mem_pinj  = 1'b0;
`endif
      if (r_state == S_INIT) begin
         w_mem_we = 1'b1;
      end else if (w_accept && req_we && w_in_range) begin
         w_mem_we    = 1'b1;
         w_mem_idx   = w_rd_idx;
         w_mem_wdata = req_wdata;
         w_mem_be    = req_be;
`ifdef BANKED_SYNC_RAM_PARITY_EN
         w_mem_pinj  = req_perr_inject;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int i = 0; i < c_NB; i++) begin
            if (w_mem_be[i]) begin
               r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
`ifdef BANKED_SYNC_RAM_PARITY_EN
               r_par[w_mem_idx][i] <= (^w_mem_wdata[8*i +: 8]) ^ w_mem_pinj;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_perr   <= '0;
      end else begin
         r_s1_valid <= w_accept & ~req_we;
         if (w_accept && !req_we) begin
            r_s1_data <= w_rd_word;
            r_s1_perr <= w_rd_perr;
         end
         case (r_state)
            S_INIT: begin
               r_cnt <= r_cnt + c_IW'(1);
               if (r_cnt == c_LAST) begin
                  r_state     <= S_RUN;
                  r_cnt       <= '0;
                  r_ready     <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            S_RUN: begin
               if (init_start) begin
                  r_state     <= S_INIT;
                  r_cnt       <= '0;
                  r_ready     <= 1'b0;
                  r_init_done <= 1'b0;
               end
            end
         endcase
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  r_s2_valid;
         logic [DATA_WIDTH-1:0] r_s2_data;
         logic [c_NB-1:0]       r_s2_perr;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_s2_valid <= 1'b0;
               r_s2_data  <= '0;
               r_s2_perr  <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_data <= r_s1_data;
                  r_s2_perr <= r_s1_perr;
               end
            end
         end

         assign rsp_valid = r_s2_valid;
         assign rsp_rdata = r_s2_data;
         assign rsp_perr  = r_s2_perr & {c_NB{r_s2_valid}};
      end else begin : g_lat1
         assign rsp_valid = r_s1_valid;
         assign rsp_rdata = r_s1_data;
         assign rsp_perr  = r_s1_perr & {c_NB{r_s1_valid}};
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_banked_sync_ram.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_banked_sync_ram                                                        |
// | Self-checking bench: directed scenarios plus random traffic vs. a model.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_banked_sync_ram;

   localparam int          AW  = 5;
   localparam int          LEN = 16;
   localparam int          RL  = 2;
   localparam int          NB  = 4;
   localparam logic [31:0] IV  = 32'hA5A5A5A5;
`ifdef BANKED_SYNC_RAM_PARITY_EN
   localparam bit          c_PAR = 1'b1;
`else
   localparam bit          c_PAR = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic [3:0]  perr;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init_start = 1'b0;
   logic          init_done;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [NB-1:0] req_be = '0;
   logic [31:0]   req_wdata = '0;
   logic          req_perr_inject = 1'b0;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic [NB-1:0] rsp_perr;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   m_run_from = 1 << 30;
   logic [31:0] m_mem [LEN];
   logic [3:0]  m_bad [LEN];
   rsp_t exp_q [$];
   rsp_t got_q [$];

   banked_sync_ram #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (32),
      .LENGTH      (LEN),
      .READ_LATENCY(RL),
      .INIT_VALUE  (IV)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .init_start     (init_start),
      .init_done      (init_done),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_be         (req_be),
      .req_wdata      (req_wdata),
      .req_perr_inject(req_perr_inject),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_perr       (rsp_perr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rsp_valid === 1'b1)
         got_q.push_back(rsp_t'{cyc: cyc, data: rsp_rdata, perr: rsp_perr});
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic model_init();
      for (int i = 0; i < LEN; i++) begin
         m_mem[i] = IV;
         m_bad[i] = '0;
      end
   endtask

   // Drives one cycle from a negedge; the model decides acceptance from the
   // cycle at which RUN is known to begin.
   task automatic drive(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        input bit inj, input bit ist);
      bit   acc;
      rsp_t e;
      req_valid = v; req_we = we; req_addr = a; req_be = be;
      req_wdata = d; req_perr_inject = inj; init_start = ist;
      acc = v && !ist && (cyc >= m_run_from);
      if (acc && we && a < LEN) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               m_mem[a[3:0]][8*i +: 8] = d[8*i +: 8];
               m_bad[a[3:0]][i]        = inj;
            end
         end
      end
      if (acc && !we) begin
         e.cyc  = cyc + RL;
         e.data = (a < LEN) ? m_mem[a[3:0]] : 32'h0;
         e.perr = (a < LEN && c_PAR) ? m_bad[a[3:0]] : 4'h0;
         exp_q.push_back(e);
      end
      if (ist && cyc >= m_run_from) begin
         m_run_from = cyc + 1 + LEN;
         model_init();
      end
      @(negedge clk);
      req_valid = 1'b0; init_start = 1'b0; req_perr_inject = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      int zeros;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({req_ready, init_done, rsp_valid, rsp_rdata, rsp_perr} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got rdy=%b done=%b vld=%b data=%h perr=%b want all 0",
                  req_ready, init_done, rsp_valid, rsp_rdata, rsp_perr);
      end
      got_q.delete(); exp_q.delete();
      req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
      rst = 1'b0;
      m_run_from = cyc + LEN;
      model_init();
      zeros = 0;
      #1;
      while (req_ready !== 1'b1 && zeros < 100) begin
         zeros++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_chk++;
      if (zeros != LEN) begin
         n_err++;
         $display("FAIL sweep_ready_low got %0d cycles want %0d", zeros, LEN);
      end
      n_chk++;
      if (init_done !== 1'b1) begin
         n_err++;
         $display("FAIL sweep_init_done got %b want 1", init_done);
      end
      n_chk++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL sweep_no_rsp got %0d responses want 0", got_q.size());
      end
   endtask

   task automatic test_init_contents();
      got_q.delete(); exp_q.delete();
      for (int a = 0; a < LEN; a++) drive(1'b1, 1'b0, AW'(a), '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != LEN) begin
         n_err++;
         $display("FAIL init_count got %0d want %0d", got_q.size(), LEN);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (got_q[i].data !== IV || got_q[i].cyc != exp_q[i].cyc) begin
            n_err++;
            $display("FAIL init_data[%0d] got %h @%0d want %h @%0d",
                     i, got_q[i].data, got_q[i].cyc, IV, exp_q[i].cyc);
         end
      end
   endtask

   task automatic test_byte_enable();
      got_q.delete(); exp_q.delete();
      drive(1'b1, 1'b1, 5'd3, 4'hF, 32'h11223344, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 5'd3, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 5'd3, '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != 1 || got_q[0].data !== 32'h11BB33DD) begin
         n_err++;
         $display("FAIL byte_enable got n=%0d data=%h want n=1 data=11bb33dd",
                  got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'hX);
      end
   endtask

   task automatic test_wr_then_rd();
      int c_w;
      got_q.delete(); exp_q.delete();
      c_w = cyc;
      drive(1'b1, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 5'd5, '0, '0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 5'(LEN), '0, '0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 5'(LEN + 3), 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 5'd3, '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != 3) begin
         n_err++;
         $display("FAIL wr_rd_count got %0d want 3", got_q.size());
      end else begin
         n_chk++;
         if (got_q[0].data !== 32'hDEADBEEF || got_q[0].cyc != c_w + 1 + RL) begin
            n_err++;
            $display("FAIL wr_then_rd got %h @%0d want deadbeef @%0d",
                     got_q[0].data, got_q[0].cyc, c_w + 1 + RL);
         end
         n_chk++;
         if (got_q[1].data !== 32'h0 || got_q[1].perr !== 4'h0) begin
            n_err++;
            $display("FAIL oor_read got %h perr %b want 0 perr 0000", got_q[1].data, got_q[1].perr);
         end
         n_chk++;
         if (got_q[2].data !== 32'h11BB33DD) begin
            n_err++;
            $display("FAIL oor_write_discard got %h want 11bb33dd", got_q[2].data);
         end
      end
   endtask

   task automatic test_back_to_back();
      int c_n;
      got_q.delete(); exp_q.delete();
      drive(1'b1, 1'b1, 5'd1, 4'hF, 32'h11110001, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 5'd2, 4'hF, 32'h22220002, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 5'd3, 4'hF, 32'h33330003, 1'b0, 1'b0);
      c_n = cyc;
      for (int a = 1; a <= 3; a++) drive(1'b1, 1'b0, AW'(a), '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != 3) begin
         n_err++;
         $display("FAIL b2b_count got %0d want 3", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (got_q[i].cyc != c_n + RL + i || got_q[i].data !== exp_q[i].data) begin
            n_err++;
            $display("FAIL b2b[%0d] got %h @%0d want %h @%0d",
                     i, got_q[i].data, got_q[i].cyc, exp_q[i].data, c_n + RL + i);
         end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      int c_rel;
      got_q.delete(); exp_q.delete();
      drive(1'b1, 1'b0, 5'd5, '0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      n_chk++;
      if ({req_ready, init_done, rsp_valid, rsp_rdata, rsp_perr} !== '0) begin
         n_err++;
         $display("FAIL mid_reset_outputs got rdy=%b done=%b vld=%b data=%h perr=%b want all 0",
                  req_ready, init_done, rsp_valid, rsp_rdata, rsp_perr);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      c_rel = cyc;
      m_run_from = c_rel + LEN;
      model_init();
      k = 0;
      while (req_ready !== 1'b1 && k < 100) begin
         k++;
         @(negedge clk);
      end
      n_chk++;
      if (cyc != c_rel + LEN) begin
         n_err++;
         $display("FAIL mid_reset_sweep ready at cycle %0d want %0d", cyc, c_rel + LEN);
      end
      n_chk++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL mid_reset_dropped got %0d responses want 0", got_q.size());
      end
      drive(1'b1, 1'b0, 5'd5, '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != 1 || got_q[0].data !== IV) begin
         n_err++;
         $display("FAIL mid_reset_reinit got n=%0d data=%h want n=1 data=%h",
                  got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'hX, IV);
      end
   endtask

   task automatic test_init_start();
      int c0;
      int k;
      got_q.delete(); exp_q.delete();
      drive(1'b1, 1'b1, 5'd7, 4'hF, 32'h12345678, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 5'd7, '0, '0, 1'b0, 1'b0);
      c0 = cyc;
      init_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7;
      #1;
      n_chk++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL init_start_ready got %b want 0", req_ready);
      end
      m_run_from = c0 + 1 + LEN;
      model_init();
      @(negedge clk);
      init_start = 1'b0; req_valid = 1'b0;
      n_chk++;
      if (init_done !== 1'b0) begin
         n_err++;
         $display("FAIL init_start_done got %b want 0", init_done);
      end
      k = 0;
      while (req_ready !== 1'b1 && k < 100) begin
         k++;
         @(negedge clk);
      end
      n_chk++;
      if (cyc != c0 + 1 + LEN || init_done !== 1'b1) begin
         n_err++;
         $display("FAIL init_start_sweep ready at %0d done=%b want %0d done=1",
                  cyc, init_done, c0 + 1 + LEN);
      end
      drive(1'b1, 1'b0, 5'd7, '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != 2) begin
         n_err++;
         $display("FAIL init_start_count got %0d want 2", got_q.size());
      end else begin
         n_chk++;
         if (got_q[0].data !== 32'h12345678 || got_q[0].cyc != exp_q[0].cyc) begin
            n_err++;
            $display("FAIL init_start_inflight got %h @%0d want 12345678 @%0d",
                     got_q[0].data, got_q[0].cyc, exp_q[0].cyc);
         end
         n_chk++;
         if (got_q[1].data !== IV) begin
            n_err++;
            $display("FAIL init_start_cleared got %h want %h", got_q[1].data, IV);
         end
      end
   endtask

   task automatic test_parity();
      logic [3:0] want;
      want = c_PAR ? 4'b0010 : 4'b0000;
      got_q.delete(); exp_q.delete();
      drive(1'b1, 1'b1, 5'd9, 4'b0010, 32'h0F0F0F0F, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 5'd9, '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (rsp_perr !== 4'h0) begin
         n_err++;
         $display("FAIL perr_idle got %b want 0000", rsp_perr);
      end
      drive(1'b1, 1'b1, 5'd9, 4'b0010, 32'h0F0F0F0F, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 5'd9, '0, '0, 1'b0, 1'b0);
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != 2) begin
         n_err++;
         $display("FAIL parity_count got %0d want 2", got_q.size());
      end else begin
         n_chk++;
         if (got_q[0].perr !== want || got_q[0].data !== 32'hA5A50FA5) begin
            n_err++;
            $display("FAIL parity_inject got perr %b data %h want perr %b data a5a50fa5",
                     got_q[0].perr, got_q[0].data, want);
         end
         n_chk++;
         if (got_q[1].perr !== 4'h0) begin
            n_err++;
            $display("FAIL parity_clean got %b want 0000", got_q[1].perr);
         end
      end
   endtask

   task automatic test_random();
      got_q.delete(); exp_q.delete();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, LEN + 3)), 4'($urandom), $urandom,
               $urandom_range(0, 3) == 0, 1'b0);
      end
      idle(RL + 2);
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_chk++;
         if (got_q[i].cyc != exp_q[i].cyc || got_q[i].data !== exp_q[i].data ||
             got_q[i].perr !== exp_q[i].perr) begin
            n_err++;
            $display("FAIL random[%0d] got %h/%b @%0d want %h/%b @%0d", i,
                     got_q[i].data, got_q[i].perr, got_q[i].cyc,
                     exp_q[i].data, exp_q[i].perr, exp_q[i].cyc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init_contents();
      test_byte_enable();
      test_wr_then_rd();
      test_back_to_back();
      test_reset_mid();
      test_init_start();
      test_parity();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/banked_sync_ram.md
Name: banked_sync_ram

Overview:
- Parametrised single-port synchronous RAM that succeeds the basic byte-wide RAM.
- Uses separate read/write data buses instead of a tristate bus, byte-lane write enables and a valid/ready request handshake.
- Read latency is configurable and reads produce a valid-tagged response.
- A hardware init sweep clears the array after reset.
- Sits between the CPU datapath/bus interface and on-chip storage.

Parameters:
ADDR_WIDTH, 10, request address width in bits
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
LENGTH, 1<<ADDR_WIDTH, number of implemented words; must be <= 2^ADDR_WIDTH
READ_LATENCY, 1, cycles from read acceptance to rsp_valid; legal values 1 or 2
INIT_VALUE, 0, word written to every location during the init sweep

Ports:
clk  input  1  clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
init_start  input  1  one-cycle pulse; restarts the init sweep when in RUN
init_done  output  1  high once the sweep completes; low during INIT
req_valid  input  1  request present
req_ready  output  1  RAM can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_be  input  DATA_WIDTH/8  byte-lane write enables; bit i controls bits [8i+7:8i]
req_wdata  input  DATA_WIDTH  write data
req_perr_inject  input  1  parity error injection for test (see Optional Feature)
rsp_valid  output  1  read data valid, one-cycle pulse
rsp_rdata  output  DATA_WIDTH  read data
rsp_perr  output  DATA_WIDTH/8  per-byte parity error flags

Behaviour:
- Reset (rst high, asynchronous):
  - FSM goes to INIT and the sweep counter is cleared to 0.
  - req_ready=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0.
  - All read-pipeline valid bits are cleared, so any in-flight read is dropped with no response.
  - Array contents are not reset directly; the sweep overwrites them.
- FSM states: INIT and RUN.
  - INIT: each cycle writes INIT_VALUE to mem[counter] and increments the counter. When the write to location LENGTH-1 completes, the next state is RUN and init_done=1. The sweep takes exactly LENGTH cycles after rst deasserts. req_ready=0 throughout.
  - RUN: req_ready=1. An init_start pulse moves the FSM to INIT on the next edge, clearing the counter and init_done. A request presented in the same cycle as init_start is not accepted. Reads already in the pipeline still complete.
- Handshake:
  - A request is accepted on a rising edge where req_valid and req_ready are both 1.
  - One request is accepted per cycle and there is no stall in RUN.
- Write:
  - On acceptance, each byte lane with req_be[i]=1 is updated; lanes with 0 keep their old value.
  - req_be=0 is a legal no-op.
  - Writes produce no response.
- Read:
  - Accepted at edge N; rsp_valid=1 during the cycle after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after acceptance.
  - rsp_rdata holds its value until the next read response.
  - The response path has no backpressure; back-to-back reads give back-to-back responses at full throughput.
- Ordering:
  - A write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
  - A read never observes a write accepted after it.
- Out of range (req_addr >= LENGTH):
  - Write is discarded.
  - Read returns all zeros with rsp_valid still asserted and rsp_perr=0.
- Read-pipeline stage registers reset to 0. With READ_LATENCY=2 the memory output is registered once more before rsp_rdata.

Optional Feature:
- Macro: BANKED_SYNC_RAM_PARITY_EN.
- Defined:
  - Each byte is stored with one extra even-parity bit computed on write.
  - If req_perr_inject=1 on an accepted write, the stored parity bit of every enabled lane is inverted.
  - On read, rsp_perr[i]=1 when stored byte i fails the parity check; rsp_perr is valid with rsp_valid and 0 otherwise.
  - The init sweep writes correct parity.
- Undefined:
  - No parity storage.
  - rsp_perr is tied to 0 and req_perr_inject is ignored.

Test Plan:
- Init sweep: LENGTH=16, INIT_VALUE=32'hA5A5A5A5; release rst and hold req_valid=1 throughout.
  - Required: req_ready=0 for exactly 16 cycles, then 1 with init_done=1.
  - Required: reading addr 0..15 returns A5A5A5A5 each time.
- Byte enables: write 32'h11223344 to addr 3 with be=4'hF, then write 32'hAABBCCDD with be=4'b0101.
  - Required: a read of addr 3 returns 32'h11BB33DD.
- Latency and throughput, READ_LATENCY=2: back-to-back reads of addr 1,2,3 accepted at edges N..N+2.
  - Required: rsp_valid high in the three cycles following edges N+1..N+3, with data in request order.
- Write-then-read: write 32'hDEADBEEF to addr 5 at edge N, read addr 5 at edge N+1.
  - Required: DEADBEEF is returned. Also read addr LENGTH (out of range) -> rsp_valid=1, rsp_rdata=0.
- Reset mid-operation: assert rst one cycle after accepting a read.
  - Required: rsp_valid never pulses; all outputs are 0 immediately on rst; a full sweep reruns after release.
  - init_start in RUN: required init_done drops the next cycle and the array returns to INIT_VALUE.
- Parity (macro defined): write 32'h0F0F0F0F, be=4'b0010, req_perr_inject=1.
  - Required: the read returns rsp_perr=4'b0010.
  - Without the macro, the same stimulus gives rsp_perr=4'b0000.
